// File: rtl/set_pkg.sv
// Shared types and constants for the SET job arbiter.
// Optional feature macro: SET_ARB_TIMEOUT_EN (RUN-state timeout abort).
package set_pkg;

   localparam int NREQ      = 4;
   localparam int ID_W      = 2;
   localparam int CENTRAL_W = 24;
   localparam int RADIUS_W  = 12;
   localparam int MODE_W    = 2;
   localparam int CAND_W    = 8;

   // FSM state encoding kept as plain constants for compatibility with
   // older tooling that inspects the raw state vector.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_LAUNCH = 2'd1;
   localparam state_t ST_RUN    = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

   // Convert a one-hot requester vector into its index (0 when empty).
   function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [ID_W-1:0] idx;
      idx = {ID_W{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) begin
            idx = ID_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: finds the first set request bit
// scanning upward (modulo NREQ) starting one position after ptr.
// Optional feature macro of the enclosing block: SET_ARB_TIMEOUT_EN (unused here).
module rr_arbiter
   import set_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant
);

   // Priority scan from ptr+1 around to ptr; the last-served requester is lowest.
   always_comb begin
      logic            found;
      logic [ID_W-1:0] idx;
      grant = {NREQ{1'b0}};
      found = 1'b0;
      idx   = {ID_W{1'b0}};
      for (int i = 1; i <= NREQ; i++) begin
         idx = ptr + ID_W'(i);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/set_job_arbiter.sv
// Round-robin arbiter feeding jobs from four requesters into one shared
// SET engine. Sequence per job: IDLE (grant) -> LAUNCH (set_en pulse)
// -> RUN (wait for set_valid) -> DONE (res_valid pulse).
// Optional feature macro: SET_ARB_TIMEOUT_EN -- when defined, a job that
// sees no set_valid within TMO_CYCLES cycles of RUN is aborted with res_err.
module set_job_arbiter
   import set_pkg::*;
#(
   parameter int TMO_CYCLES = 200
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*CENTRAL_W-1:0] job_central,
   input  logic [NREQ*RADIUS_W-1:0]  job_radius,
   input  logic [NREQ*MODE_W-1:0]    job_mode,
   output logic [NREQ-1:0]           gnt,
   output logic                      set_en,
   output logic [CENTRAL_W-1:0]      set_central,
   output logic [RADIUS_W-1:0]       set_radius,
   output logic [MODE_W-1:0]         set_mode,
   input  logic                      set_busy,
   input  logic                      set_valid,
   input  logic [CAND_W-1:0]         set_candidate,
   output logic                      res_valid,
   output logic [ID_W-1:0]           res_id,
   output logic [CAND_W-1:0]         res_candidate,
   output logic                      res_err
);

   state_t                state_r;
   logic [ID_W-1:0]       ptr_r;
   logic [ID_W-1:0]       id_r;
   logic [NREQ-1:0]       gnt_r;
   logic                  set_en_r;
   logic                  res_valid_r;
   logic [CAND_W-1:0]     cand_r;
   logic [CENTRAL_W-1:0]  central_r;
   logic [RADIUS_W-1:0]   radius_r;
   logic [MODE_W-1:0]     mode_r;
   logic [NREQ-1:0]       grant_s;
   logic [ID_W-1:0]       grant_id_s;
   // set_busy is status only; sequencing relies solely on set_valid.
   logic                  unused_inputs;

`ifdef SET_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TMO_CYCLES + 1) > 8) ? $clog2(TMO_CYCLES + 1) : 8;
   logic [CNT_W-1:0]      cnt_r;
   logic                  err_r;
   assign unused_inputs = set_busy;
   assign res_err       = err_r;
`else
   assign unused_inputs = set_busy ^ TMO_CYCLES[0];
   assign res_err       = 1'b0;
`endif

   rr_arbiter u_rr (
      .req   (req),
      .ptr   (ptr_r),
      .grant (grant_s)
   );

   assign grant_id_s = onehot_to_idx(grant_s);

   assign gnt           = gnt_r;
   assign set_en        = set_en_r;
   assign set_central   = central_r;
   assign set_radius    = radius_r;
   assign set_mode      = mode_r;
   assign res_valid     = res_valid_r;
   assign res_id        = id_r;
   assign res_candidate = cand_r;

   // Job FSM: grant/latch in IDLE, launch, wait for the engine, report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ptr_r       <= 2'd3;
         id_r        <= {ID_W{1'b0}};
         gnt_r       <= {NREQ{1'b0}};
         set_en_r    <= 1'b0;
         res_valid_r <= 1'b0;
         cand_r      <= {CAND_W{1'b0}};
         central_r   <= {CENTRAL_W{1'b0}};
         radius_r    <= {RADIUS_W{1'b0}};
         mode_r      <= {MODE_W{1'b0}};
`ifdef SET_ARB_TIMEOUT_EN
         cnt_r       <= {CNT_W{1'b0}};
         err_r       <= 1'b0;
`endif
      end else begin
         gnt_r       <= {NREQ{1'b0}};
         set_en_r    <= 1'b0;
         res_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req != {NREQ{1'b0}}) begin
                  gnt_r     <= grant_s;
                  ptr_r     <= grant_id_s;
                  id_r      <= grant_id_s;
                  central_r <= job_central[grant_id_s*CENTRAL_W +: CENTRAL_W];
                  radius_r  <= job_radius[grant_id_s*RADIUS_W +: RADIUS_W];
                  mode_r    <= job_mode[grant_id_s*MODE_W +: MODE_W];
                  state_r   <= ST_LAUNCH;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               set_en_r <= 1'b1;
               state_r  <= ST_RUN;
`ifdef SET_ARB_TIMEOUT_EN
               cnt_r    <= {CNT_W{1'b0}};
`endif
            end
            ST_RUN: begin
               if (set_valid) begin
                  cand_r      <= set_candidate;
                  res_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
`ifdef SET_ARB_TIMEOUT_EN
                  err_r       <= 1'b0;
`endif
               end
`ifdef SET_ARB_TIMEOUT_EN
               else if (cnt_r == CNT_W'(TMO_CYCLES)) begin
                  cand_r      <= {CAND_W{1'b0}};
                  err_r       <= 1'b1;
                  res_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
`else
               else begin
                  state_r <= ST_RUN;
               end
`endif
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_set_job_arbiter.sv
// Scoreboard bench for set_job_arbiter: stimulus pushes expected grant,
// launch and result records; a negedge monitor pops and compares them.
module tb_set_job_arbiter;

   typedef struct { logic [3:0] g; int mode; int at; } gexp_t;
   typedef struct { logic [23:0] c; logic [11:0] r; logic [1:0] m; } sexp_t;
   typedef struct { logic [1:0] id; logic [7:0] cand; logic err; int lat; } rexp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [95:0]  job_central;
   logic [47:0]  job_radius;
   logic [7:0]   job_mode;
   logic [3:0]   gnt;
   logic         set_en;
   logic [23:0]  set_central;
   logic [11:0]  set_radius;
   logic [1:0]   set_mode;
   logic         set_busy = 1'b0;
   logic         set_valid = 1'b0;
   logic [7:0]   set_candidate = 8'd0;
   logic         res_valid;
   logic [1:0]   res_id;
   logic [7:0]   res_candidate;
   logic         res_err;

   logic [23:0]  c_tab [4];
   logic [11:0]  r_tab [4];
   logic [1:0]   m_tab [4];

   gexp_t exp_gnt[$];
   sexp_t exp_set[$];
   rexp_t exp_res[$];

   int cyc = 0;
   int checks = 0;
   int fails = 0;
   int gnt_seen = 0, set_seen = 0, res_seen = 0;
   int last_gnt_cyc = 0, last_set_cyc = 0, last_res_cyc = 0;
   int gnt_age = 0, set_age = 0, res_age = 0;
   int eng_cnt = 0;
   bit eng_mute = 1'b0;
   bit eng_spur = 1'b0;
   logic [7:0] eng_spur_cand = 8'hEE;

   set_job_arbiter #(.TMO_CYCLES(200)) dut (
      .clk(clk), .rst(rst), .req(req),
      .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode),
      .gnt(gnt), .set_en(set_en), .set_central(set_central),
      .set_radius(set_radius), .set_mode(set_mode),
      .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
      .res_valid(res_valid), .res_id(res_id), .res_candidate(res_candidate),
      .res_err(res_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: candidate 17 returned 65 cycles after set_en.
   always @(negedge clk) begin
      if (rst) begin
         eng_cnt   = 0;
         set_valid = 1'b0;
         set_busy  = 1'b0;
      end else begin
         set_valid = 1'b0;
         if (eng_spur) begin
            set_valid     = 1'b1;
            set_candidate = eng_spur_cand;
         end
         if (eng_cnt != 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && !eng_mute) begin
               set_valid     = 1'b1;
               set_candidate = 8'd17;
            end
         end
         if (set_en) eng_cnt = 65;
         set_busy = (eng_cnt != 0);
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Monitor: compares DUT outputs against the scoreboard queues.
   always @(negedge clk) begin
      gexp_t ge; sexp_t se; rexp_t re;
      if (rst) begin
         chk("reset_outputs", 64'({gnt, set_en, res_valid, res_err, res_id, res_candidate,
                                   set_central, set_radius, set_mode}), 64'd0);
         gnt_age = 0; set_age = 0; res_age = 0;
      end else begin
         if (gnt != 4'd0) begin
            gnt_seen++;
            if (exp_gnt.size() == 0) begin
               chk("gnt_unexpected", 64'(gnt), 64'd0);
            end else begin
               ge = exp_gnt.pop_front();
               gnt_age = 0;
               chk("gnt_value", 64'(gnt), 64'(ge.g));
               if (ge.mode == 1) chk("gnt_after_done", 64'(cyc), 64'(last_res_cyc + 2));
               else if (ge.mode == 2) chk("gnt_latency", 64'(cyc), 64'(ge.at));
            end
            last_gnt_cyc = cyc;
         end
         if (set_en) begin
            set_seen++;
            chk("set_en_latency", 64'(cyc), 64'(last_gnt_cyc + 1));
            if (exp_set.size() == 0) begin
               chk("set_en_unexpected", 64'(set_en), 64'd0);
            end else begin
               se = exp_set.pop_front();
               set_age = 0;
               chk("set_fields", 64'({set_central, set_radius, set_mode}), 64'({se.c, se.r, se.m}));
            end
            last_set_cyc = cyc;
         end
         if (res_valid) begin
            res_seen++;
            if (exp_res.size() == 0) begin
               chk("res_unexpected", 64'(res_valid), 64'd0);
            end else begin
               re = exp_res.pop_front();
               res_age = 0;
               chk("res_fields", 64'({res_id, res_candidate, res_err}), 64'({re.id, re.cand, re.err}));
               if (re.lat >= 0) chk("res_latency", 64'(cyc - last_set_cyc), 64'(re.lat));
            end
            last_res_cyc = cyc;
         end
         if (exp_gnt.size() != 0) gnt_age++; else gnt_age = 0;
         if (exp_set.size() != 0) set_age++; else set_age = 0;
         if (exp_res.size() != 0) res_age++; else res_age = 0;
         if (gnt_age > 300) begin
            checks++; fails++; gnt_age = 0; void'(exp_gnt.pop_front());
            $display("FAIL gnt_timeout actual=none required=grant (cycle %0d)", cyc);
         end
         if (set_age > 300) begin
            checks++; fails++; set_age = 0; void'(exp_set.pop_front());
            $display("FAIL set_en_timeout actual=none required=set_en (cycle %0d)", cyc);
         end
         if (res_age > 400) begin
            checks++; fails++; res_age = 0; void'(exp_res.pop_front());
            $display("FAIL res_timeout actual=none required=res_valid (cycle %0d)", cyc);
         end
      end
   end

   task automatic push_job(input int i, input int mode, input logic [7:0] cand,
                           input logic err, input int lat, input bit with_res);
      gexp_t ge; sexp_t se; rexp_t re;
      ge.g = 4'b0001 << i; ge.mode = mode; ge.at = cyc + 1;
      exp_gnt.push_back(ge);
      se.c = c_tab[i]; se.r = r_tab[i]; se.m = m_tab[i];
      exp_set.push_back(se);
      if (with_res) begin
         re.id = 2'(i); re.cand = cand; re.err = err; re.lat = lat;
         exp_res.push_back(re);
      end
   endtask

   task automatic wait_gnt(input int target);
      for (int k = 0; k < 1000 && gnt_seen < target; k++) @(negedge clk);
   endtask

   task automatic wait_set(input int target);
      for (int k = 0; k < 1000 && set_seen < target; k++) @(negedge clk);
   endtask

   task automatic wait_empty();
      for (int k = 0; k < 3000 && (exp_gnt.size() + exp_set.size() + exp_res.size()) != 0; k++)
         @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      exp_gnt.delete(); exp_set.delete(); exp_res.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      int base;
      c_tab[0] = 24'h344566; r_tab[0] = 12'h222; m_tab[0] = 2'd0;
      c_tab[1] = 24'hA1B2C3; r_tab[1] = 12'h9AB; m_tab[1] = 2'd1;
      c_tab[2] = 24'h0F0F0F; r_tab[2] = 12'h0F1; m_tab[2] = 2'd2;
      c_tab[3] = 24'hFEDCBA; r_tab[3] = 12'hFFF; m_tab[3] = 2'd3;
      job_central = {c_tab[3], c_tab[2], c_tab[1], c_tab[0]};
      job_radius  = {r_tab[3], r_tab[2], r_tab[1], r_tab[0]};
      job_mode    = {m_tab[3], m_tab[2], m_tab[1], m_tab[0]};
      req = 4'b0000;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;

      // Single job from requester 0, first grant right after reset.
      @(negedge clk);
      base = gnt_seen;
      push_job(0, 2, 8'd17, 1'b0, 66, 1'b1);
      req = 4'b0001;
      wait_gnt(base + 1);
      req = 4'b0000;
      wait_empty();

      // set_valid while IDLE must be ignored.
      repeat (3) @(negedge clk);
      eng_spur = 1'b1;
      repeat (2) @(negedge clk);
      eng_spur = 1'b0;
      repeat (5) @(negedge clk);

      // All four requesting continuously: strict rotation 0,1,2,3,0,1,2,3.
      do_reset();
      @(negedge clk);
      base = gnt_seen;
      for (int k = 0; k < 8; k++) push_job(k % 4, (k == 0) ? 2 : 1, 8'd17, 1'b0, 66, 1'b1);
      req = 4'b1111;
      wait_gnt(base + 8);
      req = 4'b0000;
      wait_empty();

      // Request arriving during RUN waits until the next IDLE.
      @(negedge clk);
      base = gnt_seen;
      push_job(0, 2, 8'd17, 1'b0, 66, 1'b1);
      req = 4'b0001;
      wait_gnt(base + 1);
      req = 4'b0000;
      wait_set(set_seen + 1);
      repeat (30) @(negedge clk);
      push_job(2, 1, 8'd17, 1'b0, 66, 1'b1);
      req = 4'b0100;
      wait_gnt(base + 2);
      req = 4'b0000;
      wait_empty();

      // Reset in the middle of RUN abandons the job silently.
      @(negedge clk);
      base = gnt_seen;
      push_job(1, 2, 8'd17, 1'b0, 66, 1'b1);
      req = 4'b0010;
      wait_gnt(base + 1);
      req = 4'b0000;
      wait_set(set_seen + 1);
      repeat (29) @(negedge clk);
      do_reset();
      repeat (100) @(negedge clk);
      base = gnt_seen;
      push_job(3, 2, 8'd17, 1'b0, 66, 1'b1);
      req = 4'b1000;
      wait_gnt(base + 1);
      req = 4'b0000;
      wait_empty();

      // Engine never answers.
      @(negedge clk);
      eng_mute = 1'b1;
      base = gnt_seen;
`ifdef SET_ARB_TIMEOUT_EN
      push_job(1, 2, 8'd0, 1'b1, 201, 1'b1);
      req = 4'b0010;
      wait_gnt(base + 1);
      req = 4'b0000;
      wait_empty();
`else
      push_job(1, 2, 8'd0, 1'b0, 0, 1'b0);
      req = 4'b0010;
      wait_gnt(base + 1);
      req = 4'b0000;
      repeat (300) @(negedge clk);
      begin
         rexp_t re;
         re.id = 2'd1; re.cand = 8'hC3; re.err = 1'b0; re.lat = -1;
         exp_res.push_back(re);
      end
      eng_spur_cand = 8'hC3;
      eng_spur = 1'b1;
      repeat (2) @(negedge clk);
      eng_spur = 1'b0;
      wait_empty();
`endif
      eng_mute = 1'b0;
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/set_job_arbiter.md
SET_JOB_ARBITER -- requirements
Module: set_job_arbiter

Interface
REQ-001 Parameter TMO_CYCLES, default 200: maximum cycles the block waits in RUN for engine set_valid.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-requester job request; held high until the matching gnt bit pulses.
REQ-005 job_central  input  96  four 24-bit central words; requester i occupies bits [24i+23:24i].
REQ-006 job_radius  input  48  four 12-bit radius words; requester i occupies bits [12i+11:12i].
REQ-007 job_mode  input  8  four 2-bit mode fields; requester i occupies bits [2i+1:2i].
REQ-008 gnt  output  4  one-hot, one-cycle pulse; job of that requester accepted.
REQ-009 set_en  output  1  one-cycle start pulse to the shared SET engine.
REQ-010 set_central, set_radius, set_mode  output  24/12/2  latched job fields; stable from set_en until return to IDLE.
REQ-011 set_busy, set_valid  input  1 each  engine status.
REQ-012 set_candidate  input  8  engine result; sampled only when set_valid=1.
REQ-013 res_valid  output  1  one-cycle result pulse.
REQ-014 res_id  output  2  requester index of the result.
REQ-015 res_candidate  output  8  result count.
REQ-016 res_err  output  1  result is a timeout abort; meaningful only with res_valid.

Function
REQ-017 States: IDLE, LAUNCH, RUN, DONE; encoded in set_pkg.
REQ-018 IDLE: when req!=0, grant the first set bit searching upward, modulo 4, from ptr+1; pulse gnt, latch that requester's fields and index, set ptr to the index, go to LAUNCH.
REQ-019 IDLE with req==0: remain in IDLE with all pulse outputs low.
REQ-020 LAUNCH: assert set_en=1 for exactly one cycle, then go to RUN.
REQ-021 RUN: on set_valid=1, capture set_candidate and go to DONE; set_busy is informational only and is not used for sequencing.
REQ-022 DONE: drive res_valid=1 with res_id, res_candidate and res_err for one cycle, then go to IDLE.
REQ-023 No new grant is issued in LAUNCH, RUN or DONE; requests pending in those states are arbitrated in the next IDLE cycle.
REQ-024 Throughput: one job per (engine latency + 3) cycles minimum; grant-to-set_en latency is 1 cycle; set_valid-to-res_valid latency is 1 cycle.
REQ-025 set_valid outside RUN is ignored.
REQ-026 A req bit dropping before its grant is not an error; that requester is simply not granted.
REQ-027 Fairness: a requester with req held continuously is granted within 4 jobs.

Reset
REQ-028 rst drives state=IDLE, ptr=3 (so requester 0 has first priority), gnt=0, set_en=0, res_valid=0, res_err=0, res_id=0, res_candidate=0, set_central=0, set_radius=0, set_mode=0.
REQ-029 rst asserted mid-job abandons the job with no res_valid pulse; the first grant after rst release occurs on the first clock edge with req!=0.

Configuration
REQ-030 Macro SET_ARB_TIMEOUT_EN defined: an 8-bit-or-wider cycle counter clears on entry to RUN; if it reaches TMO_CYCLES without set_valid, go to DONE with res_err=1 and res_candidate=0.
REQ-031 Macro SET_ARB_TIMEOUT_EN undefined: no counter is built, res_err is tied 0, and RUN waits indefinitely.

Structure
REQ-032 Package set_pkg holds the state typedef, CENTRAL_W=24, RADIUS_W=12, MODE_W=2, CAND_W=8, and NREQ=4.
REQ-033 Sub-module rr_arbiter (inputs req and ptr, output one-hot grant) is combinational round-robin search logic; the FSM, field latches and timeout stay in set_job_arbiter.

Verification
REQ-034 Engine model returns candidate 8'd17 65 cycles after set_en; req=4'b0001, central=24'h344566, radius=12'h222, mode=0 -> gnt=0001, set_en 1 cycle later with identical fields, res_valid with res_id=0, res_candidate=17, res_err=0.
REQ-035 req=4'b1111 held for 8 jobs after reset -> grant order 0,1,2,3,0,1,2,3 with exactly one res_valid per grant.
REQ-036 req2 is raised during RUN of requester 0's job -> no gnt until after DONE; requester 2 is granted in the first IDLE cycle.
REQ-037 rst is pulsed at cycle 30 of RUN -> no res_valid, all outputs at reset values; a new req3 is then granted with res_id=3.
REQ-038 SET_ARB_TIMEOUT_EN defined, TMO_CYCLES=200, engine never raises set_valid -> res_valid 201 cycles after RUN entry with res_err=1 and res_candidate=0; with the macro undefined, the block stays in RUN.
